gate_bist_ctrl: RTL

Built-in self-test sequencer for one 2-input combinational gate instance (NOR by default).
- On a START request it drives all four input vectors onto the gate, optionally for several sweeps.
- After a settle delay it samples the gate output and compares it against a parameterised truth table.
- It reports per-vector failures, a saturating mismatch count and a pass flag.
- It sits between a test/config master and the gate under test.

---
 rtl/gate_bist_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for one 2-input gate: sweeps all four input vectors, checks DUT_Y against EXPECT.
// Optional macro GATE_BIST_STOP_ON_FAIL_EN: end the run at the first mismatching sample.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = 4'b0001,
  parameter int unsigned LOOPS         = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic [7:0] FAIL_COUNT,
  output logic       DUT_A,
  output logic       DUT_B,
  input  logic       DUT_Y
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [7:0]  loop_q, loop_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  count_q, count_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        mismatch;
  logic        stop;

  assign mismatch = (DUT_Y != EXPECT[vec_q]);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SETTLE;
          vec_d   = 2'd0;
          loop_d  = 8'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = 4'b0000;
          count_d = 8'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = 8'd0;
        end
      end
      S_SAMPLE: begin
        cnt_d = 8'd0;
        if (mismatch) begin
          mask_d[vec_q] = 1'b1;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
        if (!stop && vec_q != 2'd3) begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 2'd1;
        end else if (!stop && loop_q < LOOP_LAST) begin
          state_d = S_SETTLE;
          vec_d   = 2'd0;
          loop_d  = loop_q + 8'd1;
        end else begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          pass_d  = (count_d == 8'd0);
        end
        // Gate inputs follow the next vector, or return to 00 when the run ends.
        a_d = (state_d == S_SETTLE) ? vec_d[1] : 1'b0;
        b_d = (state_d == S_SETTLE) ? vec_d[0] : 1'b0;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      loop_q  <= 8'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'b0000;
      count_q <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign FAIL_MASK  = mask_q;
  assign FAIL_COUNT = count_q;
  assign DUT_A      = a_q;
  assign DUT_B      = b_q;

endmodule
